fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined RV32I core. It owns the program counter, drives the synchronous instruction ROM's enable and address, and pairs each returned instruction word with its PC for the IF/ID register. It also handles hazard-unit stalls and branch/jump redirects without losing or duplicating instructions. It sits between the hazard/branch-resolution logic and the IF/ID pipeline register, with the instruction ROM hanging off it.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `NOP_INST`, default `32'h0000_0013`: word presented on `if_inst` when `if_valid` is 0 (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: from the hazard unit; freeze the fetch stage.
- `redirect` in 1: branch/jump taken; squash the in-flight fetch.
- `redirect_pc` in 32: target address when `redirect` = 1.
- `irom_en` out 1: ROM read enable.
- `irom_adr` out 32: ROM byte address.
- `irom_inst` in 32: ROM data, valid one cycle after an enabled read. The ROM holds its output while `irom_en` = 0.
- `if_pc` out 32: PC of the instruction on `if_inst`.
- `if_inst` out 32: fetched instruction, or `NOP_INST` when not valid.
- `if_valid` out 1: `if_pc`/`if_inst` carry a real instruction.
- `fetch_fault` out 1: misaligned redirect trapped (see Configuration).

## Operation
- Registers:
  - `pc`: next address to request.
  - `rsp_pc`: PC of the outstanding or held response.
  - `rsp_valid`.
  - State `st` ∈ {RUN, FAULT}.
- Outputs:
  - `irom_adr` = `pc` (combinational from register).
  - `if_pc` = `rsp_pc`.
  - `if_valid` = `rsp_valid`.
  - `if_inst` = `rsp_valid ? irom_inst : NOP_INST`.
- `irom_en` = `st==RUN & !rst & !stall & !redirect`.
- Per-cycle priority in RUN (highest first):
  1. `rst`: `pc`←`RESET_PC`, `rsp_pc`←`RESET_PC`, `rsp_valid`←0, `st`←RUN.
  2. `redirect`: `pc`←`redirect_pc`, `rsp_valid`←0. No ROM read. `redirect` overrides `stall`.
  3. `stall`: all registers hold. `irom_en`=0, so the ROM output and therefore `if_inst` stay stable.
  4. Otherwise: `pc`←`pc+4` (modulo 2^32, wraps `FFFF_FFFC`→`0000_0000`), `rsp_pc`←`pc`, `rsp_valid`←1.
- FAULT:
  - `irom_en`=0.
  - `rsp_valid`←0.
  - `pc` holds the offending target.
  - `stall` and `redirect` are ignored.
  - FAULT is left only by `rst`.
- `fetch_fault` = (`st==FAULT`).
- Reset values of outputs:
  - `irom_en`=0, `irom_adr`=`RESET_PC`, `if_pc`=`RESET_PC`, `if_valid`=0, `if_inst`=`NOP_INST`, `fetch_fault`=0.
- The low two bits of `pc` are not masked; `irom_adr` is passed to the ROM as-is.

## Timing
- Fetch latency is 1 cycle: a request issued at edge N (`irom_en`=1, `adr`=A) gives `if_valid`=1, `if_pc`=A, and `if_inst`=ROM[A] after edge N.
- First instruction after reset: `rst` is sampled high at edge 0 and low at edge 1. The read of `RESET_PC` happens at edge 1. `if_valid`=1 with `if_pc`=`RESET_PC` after edge 1.
- Redirect penalty is 2 cycles:
  - `redirect` sampled at edge N → `if_valid`=0 after N.
  - Fetch of the target happens at N+1.
  - Target is valid after N+1.
- Stall at edge N: outputs after N equal outputs before N, bit for bit.
- Stall and redirect together: the redirect wins, as in priority 2.
- Steady state with no stall and no redirect: one instruction per cycle, `if_pc` increments by 4 each cycle.

## Configuration
- Macro `FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0] != 0` (outside reset) moves `st` to FAULT and loads `pc`←`redirect_pc`.
  - `fetch_fault` rises after that edge and stays high until `rst`.
- Undefined:
  - The FAULT state is not built and `fetch_fault` is tied to 0.
  - A misaligned redirect is treated like any other redirect; the ROM ignores `adr[1:0]`.

## Test plan
- Reset, then 5 free-running cycles, ROM[i]=`i`:
  - `if_pc` = 0, 4, 8, C, 10.
  - `if_inst` = 0, 1, 2, 3, 4.
  - `if_valid` = 1 from the first post-reset cycle.
- Stall held 3 cycles while `if_pc`=8:
  - `if_pc`=8 and `if_inst`=2 stay stable and `irom_en`=0 throughout.
  - After release the next value is `if_pc`=C.
- Redirect to `0x40` while `if_pc`=4:
  - Next cycle `if_valid`=0 and `if_inst`=`0x13`.
  - The following cycle `if_pc`=`0x40` and `if_inst`=ROM[16].
- `stall` and `redirect` (to `0x80`) asserted in the same cycle:
  - The redirect is taken and `if_pc`=`0x80` two cycles later.
- `rst` pulsed mid-run while `if_pc`=`0x20`:
  - After reset `if_valid`=0 and `if_pc`=`RESET_PC`, then fetching restarts at `RESET_PC`.
- With `FETCH_MISALIGN_TRAP_EN` defined, redirect to `0x42`:
  - `fetch_fault`=1, `if_valid`=0, and `irom_en`=0 indefinitely.
  - `rst` clears the fault and fetching restarts at `RESET_PC`.
  - Without the macro, the same stimulus fetches from `0x42` with `fetch_fault`=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IROM and pairs each returned word with its PC.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets into a sticky FAULT state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        irom_en,
    output logic [31:0] irom_adr,
    input  logic [31:0] irom_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        fetch_fault
);
    logic [31:0] pc, pc_nxt;
    logic [31:0] rsp_pc, rsp_pc_nxt;
    logic        rsp_valid, rsp_valid_nxt;
    logic        run;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic {RUN, FAULT} st_t;
    st_t st, st_nxt;

    always_ff @(posedge clk) begin
        if (rst) st <= RUN;
        else     st <= st_nxt;
    end

    // FAULT is sticky; only reset leaves it.
    always_comb begin
        st_nxt = st;
        if (st == RUN && redirect && redirect_pc[1:0] != 2'b00)
            st_nxt = FAULT;
    end

    assign run = (st == RUN);
`else
    assign run = 1'b1;
`endif

    always_comb begin
        pc_nxt        = pc;
        rsp_pc_nxt    = rsp_pc;
        rsp_valid_nxt = rsp_valid;
        if (!run) begin
            rsp_valid_nxt = 1'b0;
        end else if (redirect) begin
            // Redirect wins over stall; the in-flight response is squashed.
            pc_nxt        = redirect_pc;
            rsp_valid_nxt = 1'b0;
        end else if (!stall) begin
            pc_nxt        = pc + 32'd4;
            rsp_pc_nxt    = pc;
            rsp_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            rsp_pc    <= RESET_PC;
            rsp_valid <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            rsp_pc    <= rsp_pc_nxt;
            rsp_valid <= rsp_valid_nxt;
        end
    end

    assign irom_en     = run & !rst & !stall & !redirect;
    assign irom_adr    = pc;
    assign if_pc       = rsp_pc;
    assign if_valid    = rsp_valid;
    // The ROM holds its data while irom_en is low, so a stalled word stays stable.
    assign if_inst     = rsp_valid ? irom_inst : NOP_INST;
    assign fetch_fault = !run;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a stimulus process feeds a PC-sequence model that queues
// expected per-cycle outputs; a monitor process compares them after every rising edge.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        irom_en;
    logic [31:0] irom_adr;
    logic [31:0] irom_inst = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .irom_en(irom_en), .irom_adr(irom_adr), .irom_inst(irom_inst),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // ROM[i] = i, word-addressed; low address bits ignored.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) if (irom_en) irom_inst <= rom_word(irom_adr);

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        en;
        logic [31:0] adr;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model state: next PC to fetch, last delivered instruction, fault flag.
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_out_pc = RESET_PC;
    logic [31:0] m_out_inst = '0;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        if (r) begin
            m_pc = RESET_PC; m_out_pc = RESET_PC; m_valid = 1'b0; m_fault = 1'b0;
        end else if (m_fault) begin
            m_valid = 1'b0;
        end else if (rd) begin
            m_pc = rpc; m_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) m_fault = 1'b1;
`endif
        end else if (!s) begin
            m_out_pc = m_pc; m_out_inst = rom_word(m_pc); m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        e.valid = m_valid;
        e.pc    = m_out_pc;
        e.inst  = m_valid ? m_out_inst : NOP_INST;
        e.en    = !m_fault && !r && !s && !rd;
        e.adr   = m_pc;
        e.fault = m_fault;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("if_valid", {31'd0, if_valid}, {31'd0, e.valid});
                chk("if_pc", if_pc, e.pc);
                chk("if_inst", if_inst, e.inst);
                chk("irom_en", {31'd0, irom_en}, {31'd0, e.en});
                chk("irom_adr", irom_adr, e.adr);
                chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
            end
        end
    end

    initial begin : stim
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);          // if_pc 0,4,8
        repeat (3) step(0, 1, 0, 0);          // hold at 8
        repeat (3) step(0, 0, 0, 0);          // C,10,14
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);          // if_pc = 4
        step(0, 0, 1, 32'h40);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 1, 32'h80);                // redirect beats stall
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h1C);
        repeat (2) step(0, 0, 0, 0);          // if_pc = 0x20
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFF8);         // wrap-around
        repeat (4) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h42);                // misaligned
        repeat (4) step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 32'h100);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] tgt;
            tgt = {$urandom_range(0, 4095), 2'b00} + 32'h0;
            if ($urandom_range(0, 15) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, tgt);
        end
        step(0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
